// File: rtl/dividend_rebuild_pkg.sv
// Shared types and constants for the dividend rebuild checker.
package dividend_rebuild_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_e;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  // Bit positions within uio_in / uio_out
  localparam int START = 4;
  localparam int BUSY  = 5;
  localparam int DONE  = 6;
  localparam int ERR   = 7;

  localparam logic [RESW-1:0] UIO_OE = 8'b1110_0000;

endpackage

// File: rtl/dividend_rebuild_datapath.sv
// Shift-add multiplier plus final remainder add: acc = q*d, result = acc + r.
module dividend_rebuild_datapath
  import dividend_rebuild_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            finish_i,
  input  logic [OPW-1:0]  q_i,
  input  logic [OPW-1:0]  r_i,
  input  logic [OPW-1:0]  d_i,
  output logic [RESW-1:0] result_o,
  output logic            r_ge_d_o,
  output logic            d_zero_o
);

  logic [OPW-1:0]  q_sh_q, q_sh_d;
  logic [RESW-1:0] d_sh_q, d_sh_d;
  logic [RESW-1:0] acc_q, acc_d;
  logic [OPW-1:0]  r_q, r_d;
  logic [OPW-1:0]  d_q, d_d;

  // Final sum; r is zero-extended explicitly before the add.
  assign result_o = acc_q + {{(RESW-OPW){1'b0}}, r_q};
  assign r_ge_d_o = (r_q >= d_q);
  assign d_zero_o = (d_q == '0);

  // Next-state for capture, one multiplier step, or folding r into acc.
  always_comb begin
    q_sh_d = q_sh_q;
    d_sh_d = d_sh_q;
    acc_d  = acc_q;
    r_d    = r_q;
    d_d    = d_q;
    if (load_i) begin
      q_sh_d = q_i;
      d_sh_d = {{(RESW-OPW){1'b0}}, d_i};
      acc_d  = '0;
      r_d    = r_i;
      d_d    = d_i;
    end else if (step_i) begin
      if (q_sh_q[0]) begin
        acc_d = acc_q + d_sh_q;
      end
      d_sh_d = d_sh_q << 1;
      q_sh_d = q_sh_q >> 1;
    end else if (finish_i) begin
      acc_d = result_o;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh_q <= '0;
      d_sh_q <= '0;
      acc_q  <= '0;
      r_q    <= '0;
      d_q    <= '0;
    end else begin
      q_sh_q <= q_sh_d;
      d_sh_q <= d_sh_d;
      acc_q  <= acc_d;
      r_q    <= r_d;
      d_q    <= d_d;
    end
  end

endmodule

// File: rtl/tt_um_dividend_rebuild.sv
// Rebuilds dividend = q*d + r from a divider result and flags illegal results.
//
// state | meaning
// IDLE  | waiting for start; done/err/uo_out hold the last result
// MUL   | four shift-add steps of q*d
// ADD   | add remainder, register result and flags
module tt_um_dividend_rebuild
  import dividend_rebuild_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [RESW-1:0] res_q, res_d;

  logic            load, step, finish;
  logic [RESW-1:0] result;
  logic            r_ge_d, d_zero;
  logic            unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:5]};

  dividend_rebuild_datapath u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .step_i   (step),
    .finish_i (finish),
    .q_i      (ui_in[7:4]),
    .r_i      (ui_in[3:0]),
    .d_i      (uio_in[3:0]),
    .result_o (result),
    .r_ge_d_o (r_ge_d),
    .d_zero_o (d_zero)
  );

  assign uo_out  = res_q;
  assign uio_out = {err_q, done_q, busy_q, 5'b0_0000};
  assign uio_oe  = UIO_OE;

  // Next-state and datapath strobes; nothing moves while ena is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    res_d   = res_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (uio_in[START]) begin
            load    = 1'b1;
            cnt_d   = 2'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = MUL;
          end
        end
        MUL: begin
          step  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ADD;
          end
        end
        ADD: begin
          finish  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (d_zero) begin
            res_d = 8'hFF;
            err_d = 1'b1;
          end else begin
            res_d = result;
            err_d = r_ge_d;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and output/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: doc/tt_um_dividend_rebuild.md
# tt_um_dividend_rebuild

Sequential checker for the other end of the 4-bit unsigned divider interface. It accepts a divider result (quotient, remainder) plus the original divisor and reconstructs the dividend as quotient × divisor + remainder. It uses a 4-step shift-add multiplier followed by one add step, and flags results that cannot have come from a legal division. It sits as a standalone Tiny Tapeout user project so that divider outputs can be verified on silicon.

## Interface
Parameters:
- none; all widths are fixed at 4-bit operands and an 8-bit result.

Ports:
- clk — in — 1 — system clock; single clock domain.
- rst_n — in — 1 — reset, asynchronous, active-low.
- ena — in — 1 — enable; when low, all state holds.
- ui_in — in — 8 — [7:4] quotient q, [3:0] remainder r.
- uio_in — in — 8 — [3:0] divisor d, [4] start; [7:5] unused.
- uo_out — out — 8 — reconstructed dividend.
- uio_out — out — 8 — [5] busy, [6] done, [7] err; [4:0] driven 0.
- uio_oe — out — 8 — constant 8'b1110_0000.

## Operation
- FSM states: IDLE, MUL, ADD.
- IDLE:
  - Condition to launch: ena=1 and start=1.
  - Capture q, r, d into internal registers.
  - acc=0, step counter=0, busy=1, done=0, err=0; go to MUL.
  - start is level-sensitive. If it is held high, a new operation launches on the first IDLE cycle after completion.
- MUL (4 cycles):
  - If q_sh[0]=1, acc += d_sh (8-bit, no overflow possible).
  - d_sh <<= 1; q_sh >>= 1; counter++.
  - After the 4th step, go to ADD.
- ADD (1 cycle):
  - If d==0: uo_out=8'hFF, err=1.
  - Otherwise: uo_out=acc+r (max 15·15+15=240, fits in 8 bits), and err=1 if r>=d.
  - busy=0, done=1; go to IDLE.
- done and err stay high, and uo_out holds, until the next capture.
- start is ignored while busy.
- ena=0 freezes the FSM, counter, datapath and all outputs, in any state.
- Arithmetic is unsigned throughout. Any zero-extension is explicit: d widens 4→8 bits before shifting, r widens 4→8 bits before the add.

## Timing
- Reset values: uo_out=8'h00; busy=0, done=0, err=0; uio_out=8'h00; state IDLE; all internal registers 0.
- uio_oe is constant, including during reset.
- Latency, for an operation captured at edge E0 with ena held high:
  - MUL steps occur at E1–E4.
  - Result, done and err are registered at E5, visible after E5.
  - busy is high from after E0 until after E5.
- Back-to-back operations with start held: the next capture happens at E6, so the period is 6 cycles.
- Each cycle with ena=0 extends latency by exactly one cycle.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values. There is no partial result.
- Inputs are sampled only at the capture edge. Changes to ui_in and uio_in while busy have no effect.

## Structure
- Shared package contains:
  - FSM state enum {IDLE, MUL, ADD};
  - OPW=4 and RESW=8;
  - uio bit-position constants START, BUSY, DONE, ERR;
  - UIO_OE constant 8'b1110_0000.
- Natural sub-module: dividend_rebuild_datapath. It holds the q_sh, d_sh and acc registers and the step-add/final-add logic. Inputs: load, step, finish. Outputs: result and the r>=d / d==0 flags.
- Top level keeps the FSM, step counter, ena gating and output/flag registers.

## Test plan
- q=3, r=1, d=4, start pulse → after 5 cycles uo_out=0x0D, done=1, err=0, busy low.
- q=15, r=14, d=15 → uo_out=0xEF, err=0. q=0, r=0, d=1 → uo_out=0x00, err=0.
- q=15, r=15, d=0 → uo_out=0xFF, err=1, done=1.
- q=2, r=5, d=3 → uo_out=0x0B, err=1 (r>=d).
- Start held high across two operands (3,1,4 then 15,14,15) → second capture at E6, results 0x0D then 0xEF. A start toggle and operand change while busy → no effect.
- ena low for 2 cycles during MUL → done arrives at E7 with the correct value.
- rst_n low at E2 → immediate reset values. Restart afterwards gives the correct result.
